ir_move_scheduler: RTL and testbench
====================================

IR_MOVE_SCHEDULER -- requirements
Module: ir_move_scheduler

Interface
REQ-001 Parameter X_MAX, 639, largest legal PosX.
REQ-002 Parameter Y_MAX, 479, largest legal PosY.
REQ-003 Parameter X_INIT, 320, PosX reset value.
REQ-004 Parameter Y_INIT, 240, PosY reset value.
REQ-005 Parameter STEP, 4, pixels moved per frame tick, 1..15.
REQ-006 Parameter HOLD_FRAMES, 6, frame ticks one IR command stays active, 1..15.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, named Clock and Reset.
REQ-008 Clock  in  1  system clock, all logic on rising edge.
REQ-009 Reset  in  1  synchronous active-high reset.
REQ-010 IrValid  in  1  one-cycle strobe: IR decoder direction bits valid.
REQ-011 IrUp, IrDown, IrLeft, IrRight  in  1 each  IR decoder direction, sampled only when IrValid=1.
REQ-012 BtnUp, BtnDown, BtnLeft, BtnRight  in  1 each  debounced button levels.
REQ-013 FrameTick  in  1  one-cycle strobe at start of vertical blank.
REQ-014 PosX  out  10  cursor X coordinate.
REQ-015 PosY  out  10  cursor Y coordinate.
REQ-016 Src  out  2  active requester: 00 none, 01 IR, 10 button.
REQ-017 MoveStrobe  out  1  one-cycle pulse when PosX or PosY changed.
REQ-018 ErrCount  out  4  saturating count of rejected IR commands.

Function
REQ-019 Three states SHALL exist: IDLE (Src=00), IR (Src=01), BTN (Src=10); Src registered, reflects current state.
REQ-020 Any Btn* high SHALL force BTN next cycle from any state; BTN SHALL exit to IDLE when all Btn* low.
REQ-021 Entering BTN from IR SHALL clear the IR hold counter and stored direction; IR command is not resumed.
REQ-022 In IDLE or IR, IrValid=1 with exactly one Ir* bit high and no Btn* high SHALL store that direction, load hold counter = HOLD_FRAMES, enter/stay in IR.
REQ-023 IrValid=1 with zero or more than one Ir* bit high SHALL be ignored and ErrCount incremented, saturating at 15.
REQ-024 IrValid=1 while in BTN or while any Btn* high SHALL be dropped without ErrCount change.
REQ-025 In IR, each FrameTick without concurrent valid IrValid SHALL apply one STEP move in the stored direction and decrement hold counter; at 0 state SHALL go to IDLE same edge.
REQ-026 IrValid (valid) coincident with FrameTick SHALL win: reload direction and counter, no move on that tick.
REQ-027 An IR command SHALL therefore produce exactly HOLD_FRAMES moves if not retriggered or cancelled.
REQ-028 In BTN, each FrameTick SHALL move per axis: Up alone -> Y-STEP, Down alone -> Y+STEP, both or neither -> no Y move; Left/Right likewise on X.
REQ-029 Position registers SHALL update on the FrameTick edge; new value visible the following cycle (latency 1).
REQ-030 Arithmetic SHALL saturate: X-STEP below 0 -> 0, X+STEP above X_MAX -> X_MAX; same for Y with Y_MAX; no wrap.
REQ-031 MoveStrobe SHALL be high for the cycle after a FrameTick edge iff PosX or PosY value actually changed; clamped-at-edge ticks give no strobe.
REQ-032 FrameTick in IDLE SHALL change nothing.

Reset
REQ-033 Reset=1 at a rising edge SHALL set PosX=X_INIT, PosY=Y_INIT, Src=00, MoveStrobe=0, ErrCount=0, hold counter 0, state IDLE, regardless of other inputs.
REQ-034 Reset mid-move SHALL abort the command; no move on any later FrameTick until a new request arrives.

Verification
REQ-035 Reset, IrValid with IrRight=1, then 7 FrameTicks -> PosX 324,328,...,344 after ticks 1-6, 344 after tick 7, Src 01->00 after tick 6, 6 MoveStrobes.
REQ-036 PosX=2, BtnLeft held across 2 FrameTicks -> PosX 0 after tick 1, MoveStrobe once, tick 2 no strobe, Src=10 until release then 00.
REQ-037 IR Up active, after 2 ticks BtnDown asserted 1 tick then released -> PosY 240->236->232->236, then IDLE, later ticks no move.
REQ-038 IrValid with IrUp=IrLeft=1, then IrValid with all Ir*=0 -> ErrCount 2, state IDLE; 16 bad commands -> ErrCount 15.
REQ-039 IR Down active with 3 ticks left, valid IrValid IrLeft coincident with FrameTick -> no move that tick, then 6 X-STEP moves, PosY unchanged.
REQ-040 Reset asserted during IR move at PosX=332 -> PosX=320, Src=00, ErrCount=0 next cycle; later FrameTicks no move.

Source files
------------

// File: rtl/ir_move_scheduler.sv
// Cursor position scheduler: arbitrates IR remote commands against front-panel
// buttons and steps the cursor once per frame tick with saturating edges.
module ir_move_scheduler #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int STEP        = 4,
    parameter int HOLD_FRAMES = 6
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       IrValid,
    input  logic       IrUp,
    input  logic       IrDown,
    input  logic       IrLeft,
    input  logic       IrRight,
    input  logic       BtnUp,
    input  logic       BtnDown,
    input  logic       BtnLeft,
    input  logic       BtnRight,
    input  logic       FrameTick,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] Src,
    output logic       MoveStrobe,
    output logic [3:0] ErrCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_IR   = 2'b01,
        ST_BTN  = 2'b10
    } state_t;

    localparam logic [9:0] X_LIM = 10'(X_MAX);
    localparam logic [9:0] Y_LIM = 10'(Y_MAX);

    state_t     state;
    logic [3:0] hold;
    logic [3:0] dir;        // {up, down, left, right}, one-hot while in ST_IR
    logic [3:0] ir_bits;
    logic       any_btn;
    logic       ir_good;
    logic       move_up, move_down, move_left, move_right;
    logic [9:0] next_x, next_y;
    logic       moved;

    // Step toward zero, clamping at the lower edge instead of wrapping.
    function automatic logic [9:0] sat_dec(input logic [9:0] pos);
        logic [10:0] diff;
        diff = {1'b0, pos} - 11'(STEP);
        return diff[10] ? 10'd0 : diff[9:0];
    endfunction

    // Step away from zero, clamping at the given upper limit.
    function automatic logic [9:0] sat_inc(input logic [9:0] pos, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + 11'(STEP);
        return (sum > {1'b0, lim}) ? lim : sum[9:0];
    endfunction

    assign ir_bits = {IrUp, IrDown, IrLeft, IrRight};
    assign any_btn = BtnUp | BtnDown | BtnLeft | BtnRight;
    // A well-formed IR command is only accepted when no button owns the cursor.
    assign ir_good = IrValid & $onehot(ir_bits) & ~any_btn & (state != ST_BTN);
    assign Src     = state;

    // Decide this cycle's per-axis move and the clamped next position.
    always_comb begin
        move_up    = 1'b0;
        move_down  = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        case (state)
            // A fresh command on the tick wins; a button press cancels the IR move.
            ST_IR: if (FrameTick && !any_btn && !ir_good)
                {move_up, move_down, move_left, move_right} = dir;
            // Opposing buttons on one axis cancel out.
            ST_BTN: if (FrameTick) begin
                move_up    = BtnUp & ~BtnDown;
                move_down  = BtnDown & ~BtnUp;
                move_left  = BtnLeft & ~BtnRight;
                move_right = BtnRight & ~BtnLeft;
            end
            default: ;
        endcase
        next_x = PosX;
        if (move_left)
            next_x = sat_dec(PosX);
        else if (move_right)
            next_x = sat_inc(PosX, X_LIM);
        next_y = PosY;
        if (move_up)
            next_y = sat_dec(PosY);
        else if (move_down)
            next_y = sat_inc(PosY, Y_LIM);
        moved = (next_x != PosX) || (next_y != PosY);
    end

    // Requester arbitration, IR hold countdown, error count and position update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            hold       <= 4'd0;
            dir        <= 4'd0;
            ErrCount   <= 4'd0;
            PosX       <= 10'(X_INIT);
            PosY       <= 10'(Y_INIT);
            MoveStrobe <= 1'b0;
        end else begin
            PosX       <= next_x;
            PosY       <= next_y;
            MoveStrobe <= moved;
            if (any_btn) begin
                // Buttons pre-empt IR; an interrupted command is discarded.
                state <= ST_BTN;
                hold  <= 4'd0;
                dir   <= 4'd0;
            end else if (state == ST_BTN) begin
                state <= ST_IDLE;
            end else if (ir_good) begin
                state <= ST_IR;
                dir   <= ir_bits;
                hold  <= 4'(HOLD_FRAMES);
            end else begin
                if (IrValid && ErrCount != 4'hF)
                    ErrCount <= ErrCount + 4'd1;
                if (state == ST_IR && FrameTick) begin
                    hold <= hold - 4'd1;
                    if (hold == 4'd1) begin
                        state <= ST_IDLE;
                        dir   <= 4'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_move_scheduler.sv
// Bench for ir_move_scheduler: directed vector table, corner-case sequences
// and randomized traffic compared against a behavioural cursor model.
module tb_ir_move_scheduler;

    localparam int XMX  = 639;
    localparam int YMX  = 479;
    localparam int XI   = 320;
    localparam int YI   = 240;
    localparam int STP  = 4;
    localparam int HOLD = 6;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       IrValid = 1'b0;
    logic       IrUp = 1'b0, IrDown = 1'b0, IrLeft = 1'b0, IrRight = 1'b0;
    logic       BtnUp = 1'b0, BtnDown = 1'b0, BtnLeft = 1'b0, BtnRight = 1'b0;
    logic       FrameTick = 1'b0;
    logic [9:0] PosX, PosY;
    logic [1:0] Src;
    logic       MoveStrobe;
    logic [3:0] ErrCount;

    ir_move_scheduler #(
        .X_MAX(XMX), .Y_MAX(YMX), .X_INIT(XI), .Y_INIT(YI),
        .STEP(STP), .HOLD_FRAMES(HOLD)
    ) dut (
        .Clock(Clock), .Reset(Reset), .IrValid(IrValid),
        .IrUp(IrUp), .IrDown(IrDown), .IrLeft(IrLeft), .IrRight(IrRight),
        .BtnUp(BtnUp), .BtnDown(BtnDown), .BtnLeft(BtnLeft), .BtnRight(BtnRight),
        .FrameTick(FrameTick), .PosX(PosX), .PosY(PosY), .Src(Src),
        .MoveStrobe(MoveStrobe), .ErrCount(ErrCount)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 idle, 1 IR, 2 button; direction as signed unit vector.
    int m_x, m_y, m_mode, m_hold, m_dx, m_dy, m_err, m_stb;

    // Bit order for ir/btn vectors: [3]=Up [2]=Down [1]=Left [0]=Right.
    typedef struct {
        bit       rst;
        bit       irv;
        bit [3:0] ir;
        bit [3:0] btn;
        bit       tick;
        int       ex;
        int       ey;
        int       esrc;
        int       estb;
        int       eerr;
    } vec_t;

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit irv, input bit [3:0] ir,
                              input bit [3:0] btn, input bit tick);
        int dx, dy, nx, ny;
        bit anyb, good;
        if (rst) begin
            m_x = XI; m_y = YI; m_mode = 0; m_hold = 0;
            m_dx = 0; m_dy = 0; m_err = 0; m_stb = 0;
            return;
        end
        anyb = (btn != 4'd0);
        good = irv && ($countones(ir) == 1);
        dx = 0; dy = 0;
        if (m_mode == 2 && tick) begin
            dx = int'(btn[0]) - int'(btn[1]);
            dy = int'(btn[2]) - int'(btn[3]);
        end
        if (m_mode == 1 && tick && !anyb && !good) begin
            dx = m_dx; dy = m_dy;
        end
        nx = clamp(m_x + dx * STP, XMX);
        ny = clamp(m_y + dy * STP, YMX);
        m_stb = (nx != m_x || ny != m_y) ? 1 : 0;
        m_x = nx; m_y = ny;
        if (anyb) begin
            m_mode = 2; m_hold = 0; m_dx = 0; m_dy = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (good) begin
            m_dx = int'(ir[0]) - int'(ir[1]);
            m_dy = int'(ir[2]) - int'(ir[3]);
            m_hold = HOLD; m_mode = 1;
        end else begin
            if (irv && m_err < 15) m_err++;
            if (m_mode == 1 && tick) begin
                m_hold--;
                if (m_hold == 0) m_mode = 0;
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare every output with the model.
    task automatic step(input bit rst, input bit irv, input bit [3:0] ir,
                        input bit [3:0] btn, input bit tick);
        Reset = rst; IrValid = irv;
        {IrUp, IrDown, IrLeft, IrRight} = ir;
        {BtnUp, BtnDown, BtnLeft, BtnRight} = btn;
        FrameTick = tick;
        @(posedge Clock);
        #1;
        model_step(rst, irv, ir, btn, tick);
        chk("model_posx", int'(PosX), m_x);
        chk("model_posy", int'(PosY), m_y);
        chk("model_src", int'(Src), m_mode);
        chk("model_strobe", int'(MoveStrobe), m_stb);
        chk("model_err", int'(ErrCount), m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    vec_t vecs[12];

    initial begin
        int strobes;
        bit [3:0] rbtn;
        bit [3:0] rir;
        int run;

        // Right command held for HOLD ticks, then two malformed commands.
        vecs[0]  = '{1, 0, 4'b0000, 4'b0000, 0, 320, 240, 0, 0, 0};
        vecs[1]  = '{0, 1, 4'b0001, 4'b0000, 0, 320, 240, 1, 0, 0};
        vecs[2]  = '{0, 0, 4'b0000, 4'b0000, 1, 324, 240, 1, 1, 0};
        vecs[3]  = '{0, 0, 4'b0000, 4'b0000, 0, 324, 240, 1, 0, 0};
        vecs[4]  = '{0, 0, 4'b0000, 4'b0000, 1, 328, 240, 1, 1, 0};
        vecs[5]  = '{0, 0, 4'b0000, 4'b0000, 1, 332, 240, 1, 1, 0};
        vecs[6]  = '{0, 0, 4'b0000, 4'b0000, 1, 336, 240, 1, 1, 0};
        vecs[7]  = '{0, 0, 4'b0000, 4'b0000, 1, 340, 240, 1, 1, 0};
        vecs[8]  = '{0, 0, 4'b0000, 4'b0000, 1, 344, 240, 0, 1, 0};
        vecs[9]  = '{0, 0, 4'b0000, 4'b0000, 1, 344, 240, 0, 0, 0};
        vecs[10] = '{0, 1, 4'b1010, 4'b0000, 0, 344, 240, 0, 0, 1};
        vecs[11] = '{0, 1, 4'b0000, 4'b0000, 0, 344, 240, 0, 0, 2};

        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].irv, vecs[i].ir, vecs[i].btn, vecs[i].tick);
            chk($sformatf("vec%0d_posx", i), int'(PosX), vecs[i].ex);
            chk($sformatf("vec%0d_posy", i), int'(PosY), vecs[i].ey);
            chk($sformatf("vec%0d_src", i), int'(Src), vecs[i].esrc);
            chk($sformatf("vec%0d_strobe", i), int'(MoveStrobe), vecs[i].estb);
            chk($sformatf("vec%0d_err", i), int'(ErrCount), vecs[i].eerr);
            strobes += int'(MoveStrobe);
        end
        chk("ir_hold_strobe_count", strobes, HOLD);

        // Error counting: dropped while a button is held, then saturation at 15.
        step(1, 0, 4'd0, 4'd0, 0);
        step(0, 1, 4'b1100, 4'b1000, 0);
        chk("err_drop_btn", int'(ErrCount), 0);
        chk("err_drop_src", int'(Src), 2);
        step(0, 0, 4'd0, 4'd0, 0);
        chk("btn_release_src", int'(Src), 0);
        for (int i = 0; i < 16; i++) step(0, 1, 4'b0000, 4'd0, 0);
        chk("err_saturate", int'(ErrCount), 15);
        chk("err_state_idle", int'(Src), 0);

        // Button walk to the right edge, then to the left edge through x=3.
        step(1, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 82; i++) step(0, 0, 4'd0, 4'b0001, 1);
        chk("x_clamp_max", int'(PosX), XMX);
        chk("x_clamp_max_strobe", int'(MoveStrobe), 0);
        for (int i = 0; i < 159; i++) step(0, 0, 4'd0, 4'b0010, 1);
        chk("x_near_zero", int'(PosX), 3);
        step(0, 0, 4'd0, 4'b0010, 1);
        chk("x_clamp_zero", int'(PosX), 0);
        chk("x_clamp_zero_strobe", int'(MoveStrobe), 1);
        step(0, 0, 4'd0, 4'b0010, 1);
        chk("x_at_zero_no_strobe", int'(MoveStrobe), 0);
        chk("x_at_zero_src", int'(Src), 2);
        step(0, 0, 4'd0, 4'd0, 0);
        chk("x_release_src", int'(Src), 0);

        // IR up interrupted by a one-tick down button press.
        step(1, 0, 4'd0, 4'd0, 0);
        step(0, 1, 4'b1000, 4'd0, 0);
        step(0, 0, 4'd0, 4'd0, 1);
        chk("ir_up_t1", int'(PosY), 236);
        step(0, 0, 4'd0, 4'd0, 1);
        chk("ir_up_t2", int'(PosY), 232);
        step(0, 0, 4'd0, 4'b0100, 0);
        chk("btn_takeover_src", int'(Src), 2);
        step(0, 0, 4'd0, 4'b0100, 1);
        chk("btn_down_y", int'(PosY), 236);
        step(0, 0, 4'd0, 4'd0, 0);
        chk("after_btn_src", int'(Src), 0);
        step(0, 0, 4'd0, 4'd0, 1);
        step(0, 0, 4'd0, 4'd0, 1);
        chk("ir_not_resumed_y", int'(PosY), 236);
        chk("ir_not_resumed_strobe", int'(MoveStrobe), 0);

        // Retrigger coincident with a tick: reload wins, no move on that tick.
        step(1, 0, 4'd0, 4'd0, 0);
        step(0, 1, 4'b0100, 4'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 4'd0, 1);
        chk("ir_down_y", int'(PosY), 252);
        step(0, 1, 4'b0010, 4'd0, 1);
        chk("retrig_no_move_x", int'(PosX), 320);
        chk("retrig_no_strobe", int'(MoveStrobe), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 4'd0, 4'd0, 1);
        chk("retrig_x", int'(PosX), 296);
        chk("retrig_y", int'(PosY), 252);
        chk("retrig_done_src", int'(Src), 0);

        // Reset in the middle of an IR move.
        step(1, 0, 4'd0, 4'd0, 0);
        step(0, 1, 4'b0001, 4'd0, 0);
        step(0, 0, 4'd0, 4'd0, 1);
        step(0, 0, 4'd0, 4'd0, 1);
        step(0, 1, 4'b1100, 4'd0, 0);
        chk("pre_reset_x", int'(PosX), 328);
        step(0, 0, 4'd0, 4'd0, 1);
        chk("pre_reset_x2", int'(PosX), 332);
        step(1, 1, 4'b0001, 4'b0000, 1);
        chk("reset_x", int'(PosX), XI);
        chk("reset_src", int'(Src), 0);
        chk("reset_err", int'(ErrCount), 0);
        step(0, 0, 4'd0, 4'd0, 1);
        step(0, 0, 4'd0, 4'd0, 1);
        chk("post_reset_no_move", int'(PosX), XI);
        idle(2);

        // Randomized traffic against the model.
        rbtn = 4'd0;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rirv, rtick, rrst;
            if (run == 0) begin
                run = int'($urandom_range(1, 20));
                rbtn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            end
            run--;
            rirv = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) rir = 4'(1 << $urandom_range(0, 3));
            else rir = 4'($urandom);
            rtick = ($urandom_range(0, 2) == 0);
            rrst  = ($urandom_range(0, 399) == 0);
            step(rrst, rirv, rir, rbtn, rtick);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
